// File: rtl/rgby_pkg.sv
// Shared constants for the RGBY colour-program datapath: colour encoding,
// word geometry and the colour shift helper used by the packer.
package rgby_pkg;

  localparam int WORD_W        = 12;
  localparam int NIBS_PER_WORD = 6;
  localparam int COLOR_W       = 2;

  // Detected colour codes, as produced by the colour detector.
  typedef enum logic [COLOR_W-1:0] {
    COLOR_RED    = 2'b00,
    COLOR_GREEN  = 2'b01,
    COLOR_BLUE   = 2'b10,
    COLOR_YELLOW = 2'b11
  } color_e;

  // Append one colour at the LSB end; the oldest colour ends up in the MSBs.
  function automatic logic [WORD_W-3:0] shift_in_color(input logic [WORD_W-3:0] sr,
                                                       input logic [COLOR_W-1:0] c);
    return {sr[WORD_W-5:0], c};
  endfunction

endpackage

// File: rtl/load_checksum.sv
// XOR checksum over a cartridge load: words before the last one are folded
// into an accumulator, and the last word is compared against it.
// Built only when RGBY_LOAD_CHECKSUM_EN is defined.
module load_checksum
  import rgby_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              last_i,
  output logic              checksum_ok_o
);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic              ok_q,  ok_d;

  // Fold data words, grade the final word; a new load clears everything.
  always_comb begin
    acc_d = acc_q;
    ok_d  = ok_q;
    if (clear_i) begin
      acc_d = '0;
      ok_d  = 1'b0;
    end else if (word_valid_i) begin
      if (last_i) ok_d  = (acc_q == word_i);
      else        acc_d = acc_q ^ word_i;
    end
  end

  // Accumulator and verdict registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ok_q  <= ok_d;
    end
  end

  assign checksum_ok_o = ok_q;

endmodule

// File: rtl/cartridge_word_packer.sv
// Packs a stream of detected colours (2 bits each, MSB-first) into 12-bit
// program words and writes them to program RAM, MAX_WORDS words per load.
// Optional build macro RGBY_LOAD_CHECKSUM_EN adds the checksumOk output,
// which grades the last word of a load as an XOR of all preceding words.
module cartridge_word_packer
  import rgby_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              colorValid,
  input  logic [1:0]        color,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [11:0]       wrData,
  output logic              busy,
  output logic              loadDone,
  output logic [ADDR_W-1:0] wordCount
`ifdef RGBY_LOAD_CHECKSUM_EN
  ,
  output logic              checksumOk
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [2:0]        NIB_LAST = 3'(NIBS_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_WORDS - 1);

  logic [1:0]        state_q,      state_d;
  logic [WORD_W-3:0] shift_q,      shift_d;
  logic [2:0]        nib_q,        nib_d;
  logic              wr_en_q,      wr_en_d;
  logic [WORD_W-1:0] wr_data_q,    wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              load_done_q,  load_done_d;
  logic              accept;
  logic              last_word;

  // A colour is taken only while collecting, and start wins over it.
  assign accept    = colorValid && (state_q == ST_COLLECT) && !start;
  assign last_word = (wr_addr_q == LAST_IDX);

  // Next-state logic: packing, write issue, address advance and load control.
  // NOTE: every _d gets its hold value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    nib_d        = nib_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    load_done_d  = load_done_q;

    // The cycle after a write strobe advances the index; the last one ends the load.
    if (wr_en_q) begin
      wr_addr_d    = wr_addr_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
      if (last_word) begin
        state_d     = ST_DONE;
        load_done_d = 1'b1;
      end
    end

    // Sixth colour completes the word and frees the shifter in the same cycle,
    // so a colour arriving during the write strobe starts the next word.
    if (accept) begin
      if (nib_q == NIB_LAST) begin
        wr_en_d   = 1'b1;
        wr_data_d = {shift_q, color};
        shift_d   = '0;
        nib_d     = '0;
      end else begin
        shift_d = shift_in_color(shift_q, color);
        nib_d   = nib_q + 1'b1;
      end
    end

    // Start (re)opens a load from any state; a partial word is discarded,
    // while a strobe already on the output still completes.
    if (start) begin
      state_d      = ST_COLLECT;
      shift_d      = '0;
      nib_d        = '0;
      wr_addr_d    = '0;
      word_count_d = '0;
      load_done_d  = 1'b0;
    end
  end

  // State registers with synchronous reset overriding all inputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      nib_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      nib_q        <= nib_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
    end
  end

  assign wrEn      = wr_en_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign wordCount = word_count_q;
  assign loadDone  = load_done_q;
  assign busy      = (state_q == ST_COLLECT) || wr_en_q;

`ifdef RGBY_LOAD_CHECKSUM_EN
  load_checksum u_load_checksum (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (start),
    .word_valid_i  (wr_en_q),
    .word_i        (wr_data_q),
    .last_i        (last_word),
    .checksum_ok_o (checksumOk)
  );
`endif

endmodule

// File: tb/tb_cartridge_word_packer.sv
// Directed bench for cartridge_word_packer: a per-cycle vector table for the
// basic word, plus hand-written sequences for back-to-back colours, abort,
// end of load, reset during a write and (with RGBY_LOAD_CHECKSUM_EN) checksum.
module tb_cartridge_word_packer;
  import rgby_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, color_valid;
  logic [1:0]  color;

  logic        a_wr_en, a_busy, a_done;
  logic [7:0]  a_wr_addr, a_wcnt;
  logic [11:0] a_wr_data;
  logic        b_wr_en, b_busy, b_done;
  logic [7:0]  b_wr_addr, b_wcnt;
  logic [11:0] b_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef RGBY_LOAD_CHECKSUM_EN
  logic        a_ok, b_ok, c_ok;
  logic        c_wr_en, c_busy, c_done;
  logic [7:0]  c_wr_addr, c_wcnt;
  logic [11:0] c_wr_data;
`endif

  cartridge_word_packer #(.MAX_WORDS(64), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .colorValid(color_valid), .color(color),
    .wrEn(a_wr_en), .wrAddr(a_wr_addr), .wrData(a_wr_data), .busy(a_busy),
    .loadDone(a_done), .wordCount(a_wcnt)
`ifdef RGBY_LOAD_CHECKSUM_EN
    , .checksumOk(a_ok)
`endif
  );

  cartridge_word_packer #(.MAX_WORDS(2), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .colorValid(color_valid), .color(color),
    .wrEn(b_wr_en), .wrAddr(b_wr_addr), .wrData(b_wr_data), .busy(b_busy),
    .loadDone(b_done), .wordCount(b_wcnt)
`ifdef RGBY_LOAD_CHECKSUM_EN
    , .checksumOk(b_ok)
`endif
  );

`ifdef RGBY_LOAD_CHECKSUM_EN
  cartridge_word_packer #(.MAX_WORDS(3), .ADDR_W(8)) dut_c (
    .clk(clk), .reset(reset), .start(start), .colorValid(color_valid), .color(color),
    .wrEn(c_wr_en), .wrAddr(c_wr_addr), .wrData(c_wr_data), .busy(c_busy),
    .loadDone(c_done), .wordCount(c_wcnt), .checksumOk(c_ok)
  );
`endif

  typedef struct {
    logic        st;
    logic        cv;
    logic [1:0]  col;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic [7:0]  wcnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs sampled 1 ns after the rising edge.
  task automatic step(input logic r, input logic s, input logic cv, input logic [1:0] c);
    @(negedge clk);
    reset = r; start = s; color_valid = cv; color = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [11:0] w);
    for (int i = 0; i < NIBS_PER_WORD; i++) step(1'b0, 1'b0, 1'b1, w[11-2*i -: 2]);
  endtask

  task automatic check_a(input string tag, input logic we, input logic [7:0] ad,
                         input logic [11:0] d, input logic bz, input logic dn,
                         input logic [7:0] wc);
    check({tag, ".a.wrEn"},      32'(a_wr_en),   32'(we));
    check({tag, ".a.wrAddr"},    32'(a_wr_addr), 32'(ad));
    check({tag, ".a.wrData"},    32'(a_wr_data), 32'(d));
    check({tag, ".a.busy"},      32'(a_busy),    32'(bz));
    check({tag, ".a.loadDone"},  32'(a_done),    32'(dn));
    check({tag, ".a.wordCount"}, 32'(a_wcnt),    32'(wc));
  endtask

  task automatic check_b(input string tag, input logic we, input logic [7:0] ad,
                         input logic [11:0] d, input logic bz, input logic dn,
                         input logic [7:0] wc);
    check({tag, ".b.wrEn"},      32'(b_wr_en),   32'(we));
    check({tag, ".b.wrAddr"},    32'(b_wr_addr), 32'(ad));
    check({tag, ".b.wrData"},    32'(b_wr_data), 32'(d));
    check({tag, ".b.busy"},      32'(b_busy),    32'(bz));
    check({tag, ".b.loadDone"},  32'(b_done),    32'(dn));
    check({tag, ".b.wordCount"}, 32'(b_wcnt),    32'(wc));
  endtask

  // Watchdog: the run is a fixed number of cycles, so this only trips if the bench stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] abort_cols [6];
    logic       seen_wr;

    reset = 1'b1; start = 1'b0; color_valid = 1'b0; color = 2'b00;

    //  st  cv  col    wrEn addr  data     busy done wcnt
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b1, 2'b11, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b1, 8'd0, 12'hC6C, 1'b1, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 12'hC6C, 1'b1, 1'b0, 8'd1};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 1'b0, 8'd1, 12'hC6C, 1'b1, 1'b0, 8'd1};

    // Reset state, then colours ignored while idle.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    check_a("reset", 1'b0, 8'd0, 12'h000, 1'b0, 1'b0, 8'd0);
    check_b("reset", 1'b0, 8'd0, 12'h000, 1'b0, 1'b0, 8'd0);
`ifdef RGBY_LOAD_CHECKSUM_EN
    check("reset.c.checksumOk", 32'(c_ok), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b1, 2'b11);
    check_a("idle_cv", 1'b0, 8'd0, 12'h000, 1'b0, 1'b0, 8'd0);

    // Basic word: 11 00 01 10 11 00 -> 0xC6C at address 0.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].st, vecs[i].cv, vecs[i].col);
      check_a($sformatf("vec%0d", i), vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
              vecs[i].busy, vecs[i].done, vecs[i].wcnt);
    end

    // Back-to-back: colour in the write cycle becomes nib 1 of the next word.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    send_word(12'hAAA);
    check_a("b2b_w0", 1'b1, 8'd0, 12'hAAA, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b1, COLOR_BLUE);
    check_a("b2b_gap", 1'b0, 8'd1, 12'hAAA, 1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, COLOR_GREEN);
    check_a("b2b_w1", 1'b1, 8'd1, 12'h955, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    check_a("b2b_adv", 1'b0, 8'd2, 12'h955, 1'b1, 1'b0, 8'd2);

    // End of load on the two-word instance: twelve green colours.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, COLOR_GREEN);
      if (i == 5)  check_b("end_w0", 1'b1, 8'd0, 12'h555, 1'b1, 1'b0, 8'd0);
      if (i == 11) check_b("end_w1", 1'b1, 8'd1, 12'h555, 1'b1, 1'b0, 8'd1);
    end
    step(1'b0, 1'b0, 1'b0, 2'b00);
    check_b("end_done", 1'b0, 8'd2, 12'h555, 1'b0, 1'b1, 8'd2);
    seen_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, COLOR_RED);
      seen_wr = seen_wr | b_wr_en;
    end
    check("done_ignores_cv.wrEn", 32'(seen_wr), 32'd0);
    check_b("done_hold", 1'b0, 8'd2, 12'h555, 1'b0, 1'b1, 8'd2);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    check_b("restart", 1'b0, 8'd0, 12'h555, 1'b1, 1'b0, 8'd0);

    // Abort after three nibs: partial word discarded, next six go to address 0.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, COLOR_YELLOW);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    check_a("abort", 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0);
    abort_cols = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, abort_cols[i]);
      check($sformatf("abort_nib%0d.wrEn", i), 32'(a_wr_en), (i == 5) ? 32'd1 : 32'd0);
    end
    check_a("abort_word", 1'b1, 8'd0, 12'h6C6, 1'b1, 1'b0, 8'd0);

    // Reset during the write strobe, with start and colour also asserted.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    send_word(12'hFFF);
    check_a("pre_rst", 1'b1, 8'd0, 12'hFFF, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 2'b11);
    check_a("rst_in_wr", 1'b0, 8'd0, 12'h000, 1'b0, 1'b0, 8'd0);

    // Start and colour together: the colour is dropped.
    step(1'b0, 1'b1, 1'b1, 2'b11);
    check_a("start_cv", 1'b0, 8'd0, 12'h000, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, COLOR_GREEN);
      check($sformatf("drop_nib%0d.wrEn", i), 32'(a_wr_en), (i == 5) ? 32'd1 : 32'd0);
    end
    check_a("drop_word", 1'b1, 8'd0, 12'h555, 1'b1, 1'b0, 8'd0);

`ifdef RGBY_LOAD_CHECKSUM_EN
    // Checksum: 0x123 ^ 0x456 = 0x575.
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    send_word(12'h123); step(1'b0, 1'b0, 1'b0, 2'b00);
    send_word(12'h456); step(1'b0, 1'b0, 1'b0, 2'b00);
    send_word(12'h575);
    check("ck_good.lastWr", 32'(c_wr_data), 32'h575);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    check("ck_good.loadDone", 32'(c_done), 32'd1);
    check("ck_good.checksumOk", 32'(c_ok), 32'd1);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    check("ck_start.checksumOk", 32'(c_ok), 32'd0);
    send_word(12'h123); step(1'b0, 1'b0, 1'b0, 2'b00);
    send_word(12'h456); step(1'b0, 1'b0, 1'b0, 2'b00);
    send_word(12'h574); step(1'b0, 1'b0, 1'b0, 2'b00);
    check("ck_bad.loadDone", 32'(c_done), 32'd1);
    check("ck_bad.checksumOk", 32'(c_ok), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
